// File: rtl/counter_pkg.sv
// Shared types and constants for the 0..9999 counter controller:
// count width/typedef, default limit, ASCII command bytes, FSM states.
package counter_pkg;

  localparam int CNT_W         = 14;
  localparam int MAX_COUNT_DEF = 9999;

  typedef logic [CNT_W-1:0] count_t;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_RUN,
    OP_CLR,
    OP_MODE
  } op_t;

  localparam logic [7:0] CMD_RUN_U  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_RUN_L  = 8'h72;  // 'r'
  localparam logic [7:0] CMD_CLR_U  = 8'h43;  // 'C'
  localparam logic [7:0] CMD_CLR_L  = 8'h63;  // 'c'
  localparam logic [7:0] CMD_MODE_U = 8'h4D;  // 'M'
  localparam logic [7:0] CMD_MODE_L = 8'h6D;  // 'm'

  // Map a command byte to an operation; unknown bytes become OP_NONE.
  function automatic op_t decode_cmd(input logic [7:0] b);
    case (b)
      CMD_RUN_U,  CMD_RUN_L:  decode_cmd = OP_RUN;
      CMD_CLR_U,  CMD_CLR_L:  decode_cmd = OP_CLR;
      CMD_MODE_U, CMD_MODE_L: decode_cmd = OP_MODE;
      default:                decode_cmd = OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..TICK_COUNT-1 while en, holds while !en, and
// flags tick during the terminal cycle before reloading 0. clr wins.
module tick_gen #(
  parameter int TICK_COUNT = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_COUNT - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  // Next prescaler value and terminal-count tick.
  always_comb begin
    tick  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + 1'b1;
  end

  // Prescaler register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/counter_10k_ctrl.sv
// UART-commanded 0..MAX_COUNT up/down counter. A two-state FSM accepts one
// ASCII command byte (IDLE) and applies it in the following cycle (EXEC).
// Build option: define COUNTER_SATURATE_EN to saturate at the limits and
// stop running instead of wrapping; ports are the same either way.
module counter_10k_ctrl
  import counter_pkg::*;
#(
  parameter int TICK_COUNT = 10_000_000,
  parameter int MAX_COUNT  = MAX_COUNT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        cmd_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic [CNT_W-1:0]  counter,
  output logic              run,
  output logic              mode,
  output logic              wrap
);

  localparam count_t MAX_C = count_t'(MAX_COUNT);

  state_t     state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  count_t     counter_q, counter_d;
  logic       run_q, run_d;
  logic       mode_q, mode_d;
  logic       wrap_q, wrap_d;

  op_t  op;
  logic clr_exec;
  logic tick;
  logic sat_stop;

  assign op       = (state_q == EXEC) ? decode_cmd(cmd_q) : OP_NONE;
  assign clr_exec = (op == OP_CLR);

  tick_gen #(.TICK_COUNT(TICK_COUNT)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (run_q),
    .clr  (clr_exec),
    .tick (tick)
  );

  // Command FSM: latch the byte on accept, spend exactly one cycle in EXEC.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    cmd_ready = (state_q == IDLE);
    case (state_q)
      IDLE: if (cmd_valid) begin
        cmd_d   = cmd_data;
        state_d = EXEC;
      end
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Count update on tick (using pre-toggle mode), then command effects;
  // a clear in the same cycle as a tick discards the tick.
  always_comb begin
    counter_d = counter_q;
    run_d     = run_q;
    mode_d    = mode_q;
    wrap_d    = 1'b0;
    sat_stop  = 1'b0;
    if (tick && !clr_exec) begin
      if (!mode_q) begin
        if (counter_q >= MAX_C) begin
`ifdef COUNTER_SATURATE_EN
          counter_d = MAX_C;
          sat_stop  = 1'b1;
`else
          counter_d = '0;
`endif
          wrap_d = 1'b1;
        end else begin
          counter_d = counter_q + 1'b1;
        end
      end else begin
        if (counter_q == '0) begin
`ifdef COUNTER_SATURATE_EN
          counter_d = '0;
          sat_stop  = 1'b1;
`else
          counter_d = MAX_C;
`endif
          wrap_d = 1'b1;
        end else if (counter_q > MAX_C) begin
          counter_d = MAX_C;
        end else begin
          counter_d = counter_q - 1'b1;
        end
      end
    end
    case (op)
      OP_RUN:  run_d     = ~run_q;
      OP_CLR:  counter_d = '0;
      OP_MODE: mode_d    = ~mode_q;
      default: ;
    endcase
    if (sat_stop) run_d = 1'b0;
  end

  // State registers; reset overrides any pending command or tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      counter_q <= '0;
      run_q     <= 1'b0;
      mode_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      counter_q <= counter_d;
      run_q     <= run_d;
      mode_q    <= mode_d;
      wrap_q    <= wrap_d;
    end
  end

  assign counter = counter_q;
  assign run     = run_q;
  assign mode    = mode_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_counter_10k_ctrl.sv
// Bench for counter_10k_ctrl with TICK_COUNT = 4. Each scenario task pushes
// the expected output snapshot when it drives stimulus and pops/compares it
// when the corresponding cycle's outputs are sampled (#1 after posedge).
module tb_counter_10k_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [13:0] counter;
  logic        run, mode, wrap;

  typedef struct packed {
    logic [13:0] cnt;
    logic        run;
    logic        mode;
    logic        wrap;
    logic        rdy;
  } out_t;

  out_t exp_q[$];
  out_t e;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  counter_10k_ctrl #(.TICK_COUNT(4), .MAX_COUNT(9999)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .counter   (counter),
    .run       (run),
    .mode      (mode),
    .wrap      (wrap)
  );

  function automatic out_t obs();
    obs.cnt  = counter;
    obs.run  = run;
    obs.mode = mode;
    obs.wrap = wrap;
    obs.rdy  = cmd_ready;
  endfunction

  function automatic out_t mk(input int c, input bit r, input bit m, input bit w, input bit y);
    mk.cnt  = 14'(c);
    mk.run  = r;
    mk.mode = m;
    mk.wrap = w;
    mk.rdy  = y;
  endfunction

  function automatic string fmt(input out_t v);
    return $sformatf("cnt=%0d run=%b mode=%b wrap=%b rdy=%b", v.cnt, v.run, v.mode, v.wrap, v.rdy);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = 8'h00;
    step(2);
    rst = 1'b0;
  endtask

  // Present a byte, wait (bounded) for ready, return just after the accept edge.
  task automatic send_cmd(input logic [7:0] b);
    int g;
    g = 0;
    cmd_data = b; cmd_valid = 1'b1;
    while (!cmd_ready && g < 8) begin step(1); g++; end
    if (!cmd_ready) begin
      n_chk++; n_err++;
      $display("FAIL send_cmd_timeout got rdy=%b want rdy=1", cmd_ready);
    end
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b1; cmd_data = "r";
    exp_q.push_back(mk(0, 0, 0, 0, 1));
    step(2);
    e = exp_q.pop_front(); n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL reset_hold got %s want %s", fmt(obs()), fmt(e)); end
    rst = 1'b0; cmd_valid = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 0, 1));
    step(1);
    e = exp_q.pop_front(); n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL reset_release got %s want %s", fmt(obs()), fmt(e)); end
  endtask

  task automatic test_run();
    reset_dut();
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    send_cmd("r");
    e = exp_q.pop_front(); n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL run_accept got %s want %s", fmt(obs()), fmt(e)); end
    exp_q.push_back(mk(0, 1, 0, 0, 1));
    step(1);
    e = exp_q.pop_front(); n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL run_on got %s want %s", fmt(obs()), fmt(e)); end
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(mk(k - 1, 1, 0, 0, 1));
      step(3);
      e = exp_q.pop_front(); n_chk++;
      if (obs() !== e) begin n_err++; $display("FAIL run_pre%0d got %s want %s", k, fmt(obs()), fmt(e)); end
      exp_q.push_back(mk(k, 1, 0, 0, 1));
      step(1);
      e = exp_q.pop_front(); n_chk++;
      if (obs() !== e) begin n_err++; $display("FAIL run_step%0d got %s want %s", k, fmt(obs()), fmt(e)); end
    end
  endtask

  // Down from 0 wraps to 9999, then switch to up and wrap 9999 -> 0.
  task automatic test_wrap();
    reset_dut();
    send_cmd("m");
    exp_q.push_back(mk(0, 0, 1, 0, 1));
    step(1);
    e = exp_q.pop_front(); n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL wrap_mode_on got %s want %s", fmt(obs()), fmt(e)); end
    send_cmd("r");
    exp_q.push_back(mk(0, 1, 1, 0, 1));
    exp_q.push_back(mk(0, 1, 1, 0, 1));
`ifdef COUNTER_SATURATE_EN
    exp_q.push_back(mk(0, 0, 1, 1, 1));
    exp_q.push_back(mk(0, 0, 1, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 1));
    exp_q.push_back(mk(0, 0, 0, 0, 1));
    exp_q.push_back(mk(0, 0, 0, 0, 1));
    exp_q.push_back(mk(0, 0, 0, 0, 1));
`else
    exp_q.push_back(mk(9999, 1, 1, 1, 1));
    exp_q.push_back(mk(9999, 1, 1, 0, 0));
    exp_q.push_back(mk(9999, 1, 0, 0, 1));
    exp_q.push_back(mk(9999, 1, 0, 0, 1));
    exp_q.push_back(mk(0, 1, 0, 1, 1));
    exp_q.push_back(mk(0, 1, 0, 0, 1));
`endif
    step(1);
    e = exp_q.pop_front(); n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL wrap_run_on got %s want %s", fmt(obs()), fmt(e)); end
    step(3);
    e = exp_q.pop_front(); n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL wrap_pre got %s want %s", fmt(obs()), fmt(e)); end
    step(1);
    e = exp_q.pop_front(); n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL wrap_down got %s want %s", fmt(obs()), fmt(e)); end
    send_cmd("M");
    e = exp_q.pop_front(); n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL wrap_pulse_end got %s want %s", fmt(obs()), fmt(e)); end
    for (int k = 0; k < 4; k++) begin
      step(1);
      e = exp_q.pop_front(); n_chk++;
      if (obs() !== e) begin n_err++; $display("FAIL wrap_up_c%0d got %s want %s", k, fmt(obs()), fmt(e)); end
    end
  endtask

  // Clear landing on the tick at 57, then a mid-period clear of the prescaler.
  task automatic test_clear();
    reset_dut();
    send_cmd("r");
    exp_q.push_back(mk(0, 1, 0, 0, 1));
    step(1);
    e = exp_q.pop_front(); n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL clr_run_on got %s want %s", fmt(obs()), fmt(e)); end
    exp_q.push_back(mk(57, 1, 0, 0, 1));
    step(230);
    e = exp_q.pop_front(); n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL clr_at57 got %s want %s", fmt(obs()), fmt(e)); end
    exp_q.push_back(mk(57, 1, 0, 0, 0));
    exp_q.push_back(mk(0, 1, 0, 0, 1));
    exp_q.push_back(mk(0, 1, 0, 0, 1));
    exp_q.push_back(mk(1, 1, 0, 0, 1));
    send_cmd("c");
    e = exp_q.pop_front(); n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL clr_accept got %s want %s", fmt(obs()), fmt(e)); end
    step(1);
    e = exp_q.pop_front(); n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL clr_vs_tick got %s want %s", fmt(obs()), fmt(e)); end
    step(3);
    e = exp_q.pop_front(); n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL clr_next_pre got %s want %s", fmt(obs()), fmt(e)); end
    step(1);
    e = exp_q.pop_front(); n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL clr_next_tick got %s want %s", fmt(obs()), fmt(e)); end
    step(1);
    exp_q.push_back(mk(0, 1, 0, 0, 1));
    exp_q.push_back(mk(0, 1, 0, 0, 1));
    exp_q.push_back(mk(1, 1, 0, 0, 1));
    send_cmd("C");
    step(1);
    e = exp_q.pop_front(); n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL clr_mid got %s want %s", fmt(obs()), fmt(e)); end
    step(1);
    e = exp_q.pop_front(); n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL clr_presc_reset got %s want %s", fmt(obs()), fmt(e)); end
    step(3);
    e = exp_q.pop_front(); n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL clr_presc_tick got %s want %s", fmt(obs()), fmt(e)); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    int   idx;
    logic acc;
    bytes[0] = "x"; bytes[1] = "R"; bytes[2] = "r";
    reset_dut();
    for (int t = 0; t < 7; t++)
      exp_q.push_back(mk(0, (t == 4 || t == 5), 0, 0, (t % 2 == 0)));
    idx = 0;
    cmd_data = bytes[0]; cmd_valid = 1'b1;
    for (int t = 0; t < 7; t++) begin
      e = exp_q.pop_front(); n_chk++;
      if (obs() !== e) begin n_err++; $display("FAIL b2b_c%0d got %s want %s", t, fmt(obs()), fmt(e)); end
      acc = cmd_valid && cmd_ready;
      step(1);
      if (acc) begin
        idx++;
        if (idx < 3) cmd_data = bytes[idx];
        else         cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_rst_exec();
    reset_dut();
    send_cmd("r");
    exp_q.push_back(mk(2, 1, 0, 0, 1));
    step(9);
    e = exp_q.pop_front(); n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL rstx_before got %s want %s", fmt(obs()), fmt(e)); end
    send_cmd("m");
    rst = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 1));
    exp_q.push_back(mk(0, 0, 0, 0, 1));
    step(1);
    rst = 1'b0;
    e = exp_q.pop_front(); n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL rstx_after got %s want %s", fmt(obs()), fmt(e)); end
    step(5);
    e = exp_q.pop_front(); n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL rstx_settled got %s want %s", fmt(obs()), fmt(e)); end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = 8'h00;
    test_reset();
    test_run();
    test_wrap();
    test_clear();
    test_back_to_back();
    test_rst_exec();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got running want finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/counter_10k_ctrl.md
COUNTER_10K_CTRL -- requirements
Module: counter_10k_ctrl

Interface
REQ-001 Parameter TICK_COUNT, default 10_000_000, clk cycles per count step (10 Hz at 100 MHz).
REQ-002 Parameter MAX_COUNT, default 9999, highest count value.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 cmd_data  input  8  ASCII command byte from the UART RX FIFO.
REQ-006 cmd_valid  input  1  cmd_data valid; held until accepted.
REQ-007 cmd_ready  output  1  block can accept a command this cycle.
REQ-008 counter  output  14  current count value, 0..MAX_COUNT, fed to the FND display stage.
REQ-009 run  output  1  1 = counting, 0 = stopped.
REQ-010 mode  output  1  0 = up, 1 = down.
REQ-011 wrap  output  1  one-cycle pulse when the count wraps or saturates.

Function
REQ-012 Command FSM SHALL have states IDLE and EXEC; cmd_ready = 1 only in IDLE.
REQ-013 IDLE -> EXEC when cmd_valid && cmd_ready; the byte is registered in that cycle; EXEC -> IDLE unconditionally after one cycle.
REQ-014 Command effects SHALL become visible on outputs on the clock edge that ends EXEC; latency from accept edge to output change = 2 edges; max throughput one command per 2 cycles.
REQ-015 'R'/'r' (0x52/0x72) toggles run; 'C'/'c' (0x43/0x63) sets counter to 0 and clears the prescaler; 'M'/'m' (0x4D/0x6D) toggles mode.
REQ-016 Any other byte SHALL be consumed and ignored with no output change.
REQ-017 Prescaler counts 0..TICK_COUNT-1 only while run = 1, holds its value while run = 0, and issues an internal one-cycle tick when it equals TICK_COUNT-1 with run = 1, then reloads 0.
REQ-018 On tick: mode 0 -> counter+1, mode 1 -> counter-1.
REQ-019 Up at MAX_COUNT -> 0 with wrap = 1; down at 0 -> MAX_COUNT with wrap = 1.
REQ-020 Clear and tick in the same cycle: counter = 0, tick discarded, wrap = 0.
REQ-021 Run or mode toggle and tick in the same cycle: the tick uses the pre-toggle mode and is applied.
REQ-022 All arithmetic in 14 bits; counter SHALL never exceed MAX_COUNT.

Reset
REQ-023 On rst: counter = 0, run = 0, mode = 0, wrap = 0, prescaler = 0, FSM = IDLE (cmd_ready = 1 in the first cycle after rst deasserts).
REQ-024 rst during EXEC SHALL discard the pending command.
REQ-025 rst has priority over every command and tick.

Configuration
REQ-026 Macro COUNTER_SATURATE_EN: when defined, up at MAX_COUNT holds MAX_COUNT and down at 0 holds 0. On that tick, run is forced to 0 and wrap pulses.
REQ-027 When COUNTER_SATURATE_EN is undefined, the wrap behaviour of REQ-019 applies; ports are identical in both builds.

Structure
REQ-028 Package counter_pkg SHALL hold the command byte constants, MAX_COUNT default, the 14-bit count typedef and the FSM state enum (IDLE, EXEC).
REQ-029 Prescaler SHALL be one sub-module, tick_gen (ports clk, rst, en, clr, tick), parameterised by TICK_COUNT.

Verification (TICK_COUNT = 4)
REQ-030 rst, then 'r' -> run = 1 two edges after accept; counter = 1, 2, 3 at 4-cycle intervals.
REQ-031 counter = 9999, mode 0, run 1 -> next tick counter = 0, wrap = 1 for one cycle; with COUNTER_SATURATE_EN -> counter stays 9999, run = 0, wrap = 1.
REQ-032 counter = 0, send 'm' then run -> next tick counter = 9999, wrap = 1.
REQ-033 'c' timed so that EXEC coincides with a tick at counter = 57 -> counter = 0, wrap = 0, next tick 4 cycles later gives 1.
REQ-034 Hold cmd_valid with bytes 'x', 'R', 'r' back-to-back -> cmd_ready toggles 1/0 each cycle, 'x' ignored, run ends at 0 (two toggles).
REQ-035 Assert rst during EXEC of 'r' -> run = 0, counter = 0, cmd_ready = 1 after rst deasserts.
